// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe: programmable VGA raster generator with a pixel-clock
// divider, a centred active window and a fixed-latency colour fetch path.
// Sync and data-enable are delayed to stay aligned with the returned colour.
//
// Fetch contract: there is no valid/ready handshake. While req_valid is
// high during a pix_tick cycle, the source must present the colour for
// (req_x, req_y) on rgb_in during the pix_tick cycle PIX_LAT ticks later.
// rgb_in is sampled only in that cycle and ignored at all other times.
module vga_timing_pipe #(
  parameter int          CLK_DIV    = 4,
  parameter int          H_VISIBLE  = 640,
  parameter int          H_FRONT    = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BACK     = 48,
  parameter int          V_VISIBLE  = 480,
  parameter int          V_FRONT    = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BACK     = 33,
  parameter logic        HS_ACTIVE  = 1'b1,
  parameter logic        VS_ACTIVE  = 1'b1,
  parameter int          WIN_X0     = 64,
  parameter int          WIN_X1     = 576,
  parameter int          WIN_Y0     = 0,
  parameter int          WIN_Y1     = 480,
  parameter logic [15:0] BORDER_RGB = 16'h18E3,
  parameter int          PIX_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_tick,
  output logic [10:0] req_x,
  output logic [10:0] req_y,
  output logic        req_valid,
  input  logic [15:0] rgb_in,
  output logic        frame_start,
  output logic        line_start,
  output logic [4:0]  red,
  output logic [5:0]  green,
  output logic [4:0]  blue,
  output logic        hs,
  output logic        vs,
  output logic        de
);

  localparam int H_WHOLE  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_WHOLE  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [10:0] X_LAST   = 11'(H_WHOLE - 1);
  localparam logic [10:0] Y_LAST   = 11'(V_WHOLE - 1);
  localparam logic [10:0] WX0      = 11'(WIN_X0);
  localparam logic [10:0] WY0      = 11'(WIN_Y0);

  logic [3:0]  div;
  logic [3:0]  div_nxt;
  logic [10:0] x;
  logic [10:0] y;
  int          xi;
  int          yi;
  logic        vis;
  logic        win;
  logic        hsync_raw;
  logic        vsync_raw;
  logic [3:0]  raw;
  logic [3:0]  tail;
  logic [15:0] rgb_q;

  // Next divider value; wraps at CLK_DIV-1 (stays 0 when CLK_DIV is 1).
  always_comb begin
    div_nxt = (div == DIV_LAST) ? 4'd0 : div + 4'd1;
  end

  // Divider and registered tick: pix_tick mirrors div==CLK_DIV-1 out of
  // reset, and is forced low in the cycle after a reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= 4'd0;
      pix_tick <= 1'b0;
    end else begin
      div      <= div_nxt;
      pix_tick <= (div_nxt == DIV_LAST);
    end
  end

  // Raster counters advance once per pixel tick; y steps on the x wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= 11'd0;
      y <= 11'd0;
    end else if (pix_tick) begin
      if (x == X_LAST) begin
        x <= 11'd0;
        y <= (y == Y_LAST) ? 11'd0 : y + 11'd1;
      end else begin
        x <= x + 11'd1;
      end
    end
  end

  // Region decode done in signed int so zero-valued bounds compare cleanly.
  always_comb begin
    xi        = {21'd0, x};
    yi        = {21'd0, y};
    vis       = (xi < H_VISIBLE) && (yi < V_VISIBLE);
    hsync_raw = (xi >= HS_START) && (xi < HS_END);
    vsync_raw = (yi >= VS_START) && (yi < VS_END);
    win       = (xi >= WIN_X0) && (xi < WIN_X1) && (yi >= WIN_Y0) && (yi < WIN_Y1);
    raw       = {hsync_raw, vsync_raw, vis, win};
  end

  assign req_valid   = vis && win;
  assign req_x       = x - WX0;
  assign req_y       = y - WY0;
  assign frame_start = pix_tick && (x == 11'd0) && (y == 11'd0);
  assign line_start  = pix_tick && (x == 11'd0);

  generate
    if (PIX_LAT == 0) begin : g_no_dly
      assign tail = raw;
    end else begin : g_dly
      logic [3:0] dly [PIX_LAT];

      // Region flags shift one stage per tick to match the source latency.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PIX_LAT; i++) dly[i] <= 4'd0;
        end else if (pix_tick) begin
          dly[0] <= raw;
          for (int i = 1; i < PIX_LAT; i++) dly[i] <= dly[i-1];
        end
      end

      assign tail = dly[PIX_LAT-1];
    end
  endgenerate

  // Output stage: sync polarity, data enable and colour select at the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs    <= ~HS_ACTIVE;
      vs    <= ~VS_ACTIVE;
      de    <= 1'b0;
      rgb_q <= 16'h0000;
    end else if (pix_tick) begin
      hs <= tail[3] ? HS_ACTIVE : ~HS_ACTIVE;
      vs <= tail[2] ? VS_ACTIVE : ~VS_ACTIVE;
      de <= tail[1];
      if (tail[1] && tail[0])
        rgb_q <= rgb_in;
      else if (tail[1])
        rgb_q <= BORDER_RGB;
      else
        rgb_q <= 16'h0000;
    end
  end

  assign red   = rgb_q[15:11];
  assign green = rgb_q[10:5];
  assign blue  = rgb_q[4:0];

endmodule

// File: doc/vga_timing_pipe.md
Name: vga_timing_pipe

Overview:
Parametrised VGA raster generator with programmable timings, pixel-clock divider, sync polarities and centred active window. Issues per-pixel fetch requests (x, y, valid) to a downstream framebuffer or tile renderer. Samples the returned colour after a fixed PIX_LAT pixel ticks. Delays hs/vs/de by the same amount so colour and syncs leave aligned. Sits between the pixel source (PPU/framebuffer) and the board RGB565 DAC pins.

Parameters:
CLK_DIV, 4, clk cycles per pixel tick; legal range 1..16
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BACK, 48, horizontal back porch
V_VISIBLE, 480, visible lines
V_FRONT, 10, vertical front porch
V_SYNC, 2, vertical sync width
V_BACK, 33, vertical back porch
HS_ACTIVE, 1, level of hs during sync pulse
VS_ACTIVE, 1, level of vs during sync pulse
WIN_X0, 64, first x of active window (inclusive)
WIN_X1, 576, end x of active window (exclusive)
WIN_Y0, 0, first y of window (inclusive)
WIN_Y1, 480, end y of window (exclusive)
BORDER_RGB, 16'h18E3, RGB565 colour for visible pixels outside the window
PIX_LAT, 1, pixel ticks between request and rgb_in valid; 0..7

Ports:
clk  in  1  system clock (100 MHz on board)
rst  in  1  synchronous reset, active high
pix_tick  out  1  one-clk strobe, pixel-clock enable
req_x  out  11  window-relative x of pixel being requested (x - WIN_X0)
req_y  out  11  window-relative y (y - WIN_Y0)
req_valid  out  1  current raster position is inside visible area and window
rgb_in  in  16  RGB565 colour from source, valid PIX_LAT ticks after request
frame_start  out  1  one-clk pulse, raster at x=0,y=0
line_start  out  1  one-clk pulse, raster at x=0 (any y)
red  out  5  red output
green  out  6  green output
blue  out  5  blue output
hs  out  1  horizontal sync, polarity per HS_ACTIVE
vs  out  1  vertical sync, polarity per VS_ACTIVE
de  out  1  data-enable, high on visible pixels at output stage

Behaviour:
- Divider: div counts 0..CLK_DIV-1 on every clk. pix_tick=1 when div==CLK_DIV-1. CLK_DIV=1 gives pix_tick constantly high.
- Raster counters x,y are 11 bit and advance only on pix_tick. H_WHOLE=sum of H params; V_WHOLE=sum of V params.
- x wraps H_WHOLE-1 -> 0. y increments when x wraps, and y wraps V_WHOLE-1 -> 0 simultaneously with the x wrap.
- Region decode from current (x,y), combinational:
  - vis = x<H_VISIBLE && y<V_VISIBLE
  - hsync_raw = H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC
  - vsync_raw likewise on y
  - win = WIN_X0<=x<WIN_X1 && WIN_Y0<=y<WIN_Y1
- Request stage: req_valid=vis&&win, combinational from counters. req_x/req_y are valid only while req_valid=1 and are don't-care otherwise.
- frame_start / line_start: asserted during the clk where pix_tick=1 and the counters currently read (0,0) / (0,y).
- Delay line: PIX_LAT-deep shift register of {hsync_raw, vsync_raw, vis, win}, shifted on pix_tick only. PIX_LAT=0 means no delay stage.
- Output stage registers load on pix_tick from the delay-line tail:
  - hs = hsync_raw ? HS_ACTIVE : ~HS_ACTIVE; vs likewise with VS_ACTIVE.
  - de = vis.
  - {red,green,blue} = vis&&win ? rgb_in : vis ? BORDER_RGB : 0.
  - Outside the visible area, colour is forced to 0.
- Total latency from counter value to pins: PIX_LAT+1 pixel ticks. rgb_in is sampled exactly at that output-load pix_tick.
- Outputs hold between pix_ticks.
- Reset (any cycle, including mid-line or mid-frame): div=0, x=0, y=0, delay line cleared to all-zero fields.
  - Output regs: red/green/blue=0, de=0, hs=~HS_ACTIVE, vs=~VS_ACTIVE, pix_tick=0.
  - First pix_tick occurs CLK_DIV clk after rst deasserts.
  - First frame_start coincides with the first pix_tick.
- Window bounds beyond visible area are clipped by vis. WIN_X0>=WIN_X1 gives an empty window (all-border screen).
- No back-pressure: source must return rgb_in at fixed latency.

Test Plan:
- Defaults, reset then run 2 frames -> pix_tick every 4 clk; line period 3200 clk; frame period 1,680,000 clk; frame_start exactly once per frame.
- Defaults, measure hs -> low at reset; high for 96 ticks (384 clk) starting (PIX_LAT+1)=2 ticks after counter x=656. vs high for 2 lines starting on line 490+ (delayed 2 ticks).
- rgb_in driven as {req_x[4:0],req_y[5:0],5'h0} delayed 1 tick (model source) -> output pixel at raster (64,0) = 0x0000, (65,3) = 0x0860; columns 0..63 and 576..639 = 0x18E3; x>=640 = 0, de=0.
- HS_ACTIVE=0, VS_ACTIVE=0, CLK_DIV=1, PIX_LAT=3 -> hs idles high, pulses low 96 clk; rgb aligned with 3-tick-delayed source model; no misalignment over full frame.
- Assert rst for 1 clk at x=300,y=200 -> next clk all outputs at reset values; frame_start on 4th clk after release; following line_start 3200 clk later.
- WIN_X0=700 (empty window) -> req_valid never high; all visible pixels = BORDER_RGB.
